// File: rtl/addsub_stim_checker_pkg.sv
// addsub_chk_pkg: shared types, constants and the reference model for the add/sub stimulus checker.
package addsub_chk_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [31:0] LFSR_MASK   = 32'h8020_0003;
    localparam int          DEF_LATENCY = 2;
    localparam logic [31:0] DEF_SEED    = 32'h0000_0001;

    // a = low half, b = high half, bit 0 selects add (1) or subtract (0)
    function automatic logic [31:0] expected_result(input logic [31:0] v);
        logic [31:0] a;
        logic [31:0] b;
        a = {16'h0, v[15:0]};
        b = {16'h0, v[31:16]};
        return v[0] ? a + b : a - b;
    endfunction

endpackage

// File: rtl/addsub_stim_checker_if.sv
// addsub_stim_checker_if: control, status and datapath-loop signals of the stimulus checker.
//   master: drives start/num_vectors and returns the datapath result
//   slave : the checker; drives stimulus and run status
interface addsub_stim_checker_if #(parameter int WIDTH = 32);
    logic             start;
    logic [15:0]      num_vectors;
    logic [WIDTH-1:0] stim_out;
    logic [WIDTH-1:0] dut_result;
    logic             busy;
    logic             done;
    logic             pass;
    logic [15:0]      err_count;
    logic [15:0]      first_err_idx;

    modport master (
        output start, num_vectors, dut_result,
        input  stim_out, busy, done, pass, err_count, first_err_idx
    );
    modport slave (
        input  start, num_vectors, dut_result,
        output stim_out, busy, done, pass, err_count, first_err_idx
    );
endinterface

// File: rtl/addsub_stim_checker_lfsr.sv
// lfsr32: 32-bit Galois LFSR on the falling edge.
//   load  : take seed (priority over advance)
//   advance: step one position
//   q     : current state
module lfsr32
    import addsub_chk_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        advance,
    input  logic [31:0] seed,
    output logic [31:0] q
);
    always_ff @(negedge clk) begin
        if (rst)
            q <= 32'h1;
        else if (load)
            q <= seed;
        else if (advance)
            q <= {1'b0, q[31:1]} ^ (q[0] ? LFSR_MASK : 32'h0);
    end
endmodule

// File: rtl/addsub_stim_checker.sv
// addsub_stim_checker: drives pseudo-random vectors into the add/sub datapath and checks its results.
//   clk, rst : falling-edge clock, synchronous active-high reset
//   bus      : start/num_vectors in, stim_out to datapath, dut_result back,
//              busy/done/pass/err_count/first_err_idx status
module addsub_stim_checker
    import addsub_chk_pkg::*;
#(
    parameter int          WIDTH   = 32,
    parameter int          LATENCY = DEF_LATENCY,
    parameter logic [31:0] SEED    = DEF_SEED
)(
    input logic clk,
    input logic rst,
    addsub_stim_checker_if.slave bus
);
    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

    state_t           state;
    logic [15:0]      vec_cnt;
    logic [15:0]      n_vec;
    logic [7:0]       drain_cnt;
    logic [WIDTH-1:0] stim_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [15:0]      err_count;
    logic [15:0]      first_err_idx;
    logic [31:0]      lfsr_q;

    // entry [LATENCY] is the one being compared this edge
    logic             dl_vld [LATENCY+1];
    logic [WIDTH-1:0] dl_exp [LATENCY+1];
    logic [15:0]      dl_idx [LATENCY+1];

    logic        accept;
    logic        mismatch;
    logic [15:0] err_next;

    assign accept   = bus.start && (state == IDLE || state == DONE);
    assign mismatch = dl_vld[LATENCY] && (dl_exp[LATENCY] != bus.dut_result);
    assign err_next = (mismatch && err_count != 16'hFFFF) ? err_count + 16'd1 : err_count;

    lfsr32 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .advance (state == RUN),
        .seed    (SEED_EFF),
        .q       (lfsr_q)
    );

    always_ff @(negedge clk) begin
        if (rst) begin
            state         <= IDLE;
            vec_cnt       <= '0;
            n_vec         <= '0;
            drain_cnt     <= '0;
            stim_out      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= 16'hFFFF;
            for (int i = 0; i <= LATENCY; i++) dl_vld[i] <= 1'b0;
        end else begin
            for (int i = 1; i <= LATENCY; i++) begin
                dl_vld[i] <= dl_vld[i-1];
                dl_exp[i] <= dl_exp[i-1];
                dl_idx[i] <= dl_idx[i-1];
            end
            dl_vld[0] <= (state == RUN);
            dl_exp[0] <= expected_result(lfsr_q);
            dl_idx[0] <= vec_cnt;
            stim_out  <= (state == RUN) ? lfsr_q : '0;
            err_count <= err_next;
            // err_count==0 marks the first mismatch of the run
            if (mismatch && err_count == 16'h0)
                first_err_idx <= dl_idx[LATENCY];
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        n_vec         <= bus.num_vectors;
                        vec_cnt       <= '0;
                        drain_cnt     <= '0;
                        err_count     <= '0;
                        first_err_idx <= 16'hFFFF;
                        pass          <= 1'b0;
                        done          <= 1'b0;
                        busy          <= 1'b1;
                        state         <= (bus.num_vectors == 16'h0) ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    vec_cnt <= vec_cnt + 16'd1;
                    if (vec_cnt == n_vec - 16'd1)
                        state <= DRAIN;
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + 8'd1;
                    // the last vector is compared on this same edge, so use err_next
                    if (drain_cnt == 8'(LATENCY)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == 16'h0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.stim_out      = stim_out;
    assign bus.busy          = busy;
    assign bus.done          = done;
    assign bus.pass          = pass;
    assign bus.err_count     = err_count;
    assign bus.first_err_idx = first_err_idx;
endmodule

// File: tb/tb_addsub_stim_checker.sv
// tb_addsub_stim_checker: directed checks of the stimulus checker against a behavioural add/sub datapath.
module tb_addsub_stim_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    addsub_stim_checker_if bus ();

    logic        start = 1'b0;
    logic [15:0] num   = 16'd0;
    int          mode  = 0;
    logic [31:0] r1 = 32'h0, r2 = 32'h0;

    function automatic logic [31:0] tb_f(input logic [31:0] v);
        logic [31:0] a;
        logic [31:0] b;
        a = {16'h0, v[15:0]};
        b = {16'h0, v[31:16]};
        return v[0] ? a + b : a - b;
    endfunction

    function automatic logic [31:0] tb_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    // two-stage falling-edge datapath model with fault modes
    always @(negedge clk) begin
        r1 <= tb_f(bus.stim_out);
        r2 <= r1;
    end

    assign bus.start       = start;
    assign bus.num_vectors = num;
    assign bus.dut_result  = (mode == 1) ? (r2 & ~32'h20) : (mode == 2) ? ~r2 : r2;

    addsub_stim_checker u_dut (.clk(clk), .rst(rst), .bus(bus));

    logic        bstart = 1'b0;
    logic [31:0] bres  [3];
    logic        bdone [3];
    logic        bpass [3];
    logic [15:0] berr  [3];
    logic [15:0] bfidx [3];

    for (genvar g = 0; g < 3; g++) begin : gb
        localparam logic [31:0] S = (g == 0) ? 32'h0001_0000 : (g == 1) ? 32'hFFFF_FFFF : 32'h0;
        addsub_stim_checker_if bi ();
        assign bi.start       = bstart;
        assign bi.num_vectors = 16'd1;
        assign bi.dut_result  = bres[g];
        assign bdone[g] = bi.done;
        assign bpass[g] = bi.pass;
        assign berr[g]  = bi.err_count;
        assign bfidx[g] = bi.first_err_idx;
        addsub_stim_checker #(.SEED(S)) u_b (.clk(clk), .rst(rst), .bus(bi));
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [31:0] model_seq [100];
    logic [31:0] cap [128];
    int          busy_cnt;
    logic        stim_nz;
    logic        timed_out;

    task automatic run(input logic [15:0] n, input int pulse_at);
        start = 1'b1;
        num   = n;
        @(posedge clk);
        start     = 1'b0;
        busy_cnt  = 0;
        stim_nz   = 1'b0;
        timed_out = 1'b1;
        for (int j = 0; j < 70000; j++) begin
            if (bus.busy) busy_cnt++;
            if (bus.stim_out != 32'h0) stim_nz = 1'b1;
            if (j >= 1 && j <= 128) cap[j-1] = bus.stim_out;
            start = (j == pulse_at);
            if (bus.done) begin
                timed_out = 1'b0;
                break;
            end
            @(posedge clk);
        end
        start = 1'b0;
        check("run_timeout", 32'(timed_out), 32'd0);
    endtask

    task automatic b_run();
        bstart = 1'b1;
        @(posedge clk);
        bstart = 1'b0;
        for (int j = 0; j < 10; j++) begin
            if (bdone[0] && bdone[1] && bdone[2]) break;
            @(posedge clk);
        end
        check("b_done", 32'(bdone[0] && bdone[1] && bdone[2]), 32'd1);
    endtask

    initial begin
        int          cnt5;
        int          first5;
        int          bad;
        logic [31:0] s;
        s = 32'h1;
        for (int i = 0; i < 100; i++) begin
            model_seq[i] = s;
            s = tb_step(s);
        end
        cnt5 = 0;
        first5 = 16'hFFFF;
        for (int i = 0; i < 100; i++)
            if (tb_f(model_seq[i])[5]) begin
                if (cnt5 == 0) first5 = i;
                cnt5++;
            end

        repeat (3) @(posedge clk);
        check("rst_stim", bus.stim_out, 32'h0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_pass", 32'(bus.pass), 32'd0);
        check("rst_err", 32'(bus.err_count), 32'd0);
        check("rst_fidx", 32'(bus.first_err_idx), 32'hFFFF);
        rst = 1'b0;
        @(posedge clk);

        run(16'd100, 20);
        check("good_busy_edges", 32'(busy_cnt), 32'd103);
        check("good_pass", 32'(bus.pass), 32'd1);
        check("good_err", 32'(bus.err_count), 32'd0);
        check("good_fidx", 32'(bus.first_err_idx), 32'hFFFF);
        check("good_stim_idle", bus.stim_out, 32'h0);
        check("vec0", cap[0], 32'h0000_0001);
        check("vec1", cap[1], 32'h8020_0003);
        check("vec2", cap[2], 32'hC030_0002);
        check("vec3", cap[3], 32'h6018_0001);
        check("vec4", cap[4], 32'hB02C_0003);
        bad = 0;
        for (int i = 0; i < 100; i++) if (cap[i] !== model_seq[i]) bad++;
        check("seq_mismatches", 32'(bad), 32'd0);

        mode = 1;
        run(16'd100, -1);
        check("bit5_pass", 32'(bus.pass), 32'd0);
        check("bit5_err", 32'(bus.err_count), 32'(cnt5));
        check("bit5_fidx", 32'(bus.first_err_idx), 32'(first5));
        check("bit5_nonzero", 32'(cnt5 > 0), 32'd1);

        mode = 0;
        run(16'd100, -1);
        check("rerun_pass", 32'(bus.pass), 32'd1);
        check("rerun_err", 32'(bus.err_count), 32'd0);
        check("rerun_fidx", 32'(bus.first_err_idx), 32'hFFFF);

        run(16'd0, -1);
        check("zero_edges", 32'(busy_cnt), 32'd3);
        check("zero_pass", 32'(bus.pass), 32'd1);
        check("zero_stim", 32'(stim_nz), 32'd0);

        start = 1'b1;
        num   = 16'd100;
        @(posedge clk);
        start = 1'b0;
        repeat (40) @(posedge clk);
        rst = 1'b1;
        @(posedge clk);
        check("mid_rst_stim", bus.stim_out, 32'h0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check("mid_rst_pass", 32'(bus.pass), 32'd0);
        check("mid_rst_err", 32'(bus.err_count), 32'd0);
        check("mid_rst_fidx", 32'(bus.first_err_idx), 32'hFFFF);
        rst = 1'b0;
        @(posedge clk);
        run(16'd100, -1);
        bad = 0;
        for (int i = 0; i < 100; i++) if (cap[i] !== model_seq[i]) bad++;
        check("restart_seq_mismatches", 32'(bad), 32'd0);
        check("restart_pass", 32'(bus.pass), 32'd1);

        bres[0] = 32'hFFFF_FFFF;
        bres[1] = 32'h0001_FFFE;
        bres[2] = 32'h0000_0001;
        b_run();
        for (int g = 0; g < 3; g++) begin
            check($sformatf("bound%0d_pass", g), 32'(bpass[g]), 32'd1);
            check($sformatf("bound%0d_err", g), 32'(berr[g]), 32'd0);
        end
        for (int g = 0; g < 3; g++) bres[g] = 32'h0;
        b_run();
        for (int g = 0; g < 3; g++) begin
            check($sformatf("bound%0d_bad_pass", g), 32'(bpass[g]), 32'd0);
            check($sformatf("bound%0d_bad_err", g), 32'(berr[g]), 32'd1);
            check($sformatf("bound%0d_bad_fidx", g), 32'(bfidx[g]), 32'd0);
        end

        mode = 2;
        run(16'hFFFF, -1);
        check("sat_err", 32'(bus.err_count), 32'hFFFF);
        check("sat_pass", 32'(bus.pass), 32'd0);
        check("sat_fidx", 32'(bus.first_err_idx), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
